// File: rtl/matmul_host_sequencer.sv
// Host-side sequencer for the matrix-multiply core: streams X then Y into the core RAMs,
// starts the core, waits for it to go idle, then streams the Z results out row-major.
module matmul_host_sequencer #(
   parameter int ADDR_WIDTH    = 4,
   parameter int DATA_WIDTH    = 32,
   parameter int X_ROWS        = 2,
   parameter int Y_COLS        = 2,
   parameter int X_COLS_Y_ROWS = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   output logic                  seq_busy,
   output logic [ADDR_WIDTH-1:0] mm_addr,
   output logic                  mm_wen,
   output logic [1:0]            mm_sel,
   output logic [DATA_WIDTH-1:0] mm_wdata,
   output logic                  mm_start,
   input  logic                  mm_busy,
   input  logic [DATA_WIDTH-1:0] mm_rdata
);

   localparam int NX = X_ROWS * X_COLS_Y_ROWS;
   localparam int NY = X_COLS_Y_ROWS * Y_COLS;
   localparam int NZ = X_ROWS * Y_COLS;
   localparam logic [ADDR_WIDTH-1:0] C_X_LAST = ADDR_WIDTH'(NX - 1);
   localparam logic [ADDR_WIDTH-1:0] C_Y_LAST = ADDR_WIDTH'(NY - 1);
   localparam logic [ADDR_WIDTH-1:0] C_Z_LAST = ADDR_WIDTH'(NZ - 1);

   if (NX > (1 << ADDR_WIDTH) || NY > (1 << ADDR_WIDTH) || NZ > (1 << ADDR_WIDTH)) begin : g_cfg_check
      $error("matmul_host_sequencer: matrix size exceeds core RAM address range");
   end

   typedef enum logic [3:0] {
      S_LOAD_X, S_LOAD_Y, S_DRAIN, S_START, S_ARM, S_WAIT, S_RD_ISSUE, S_RD_CAPTURE, S_OUT
   } state_t;

   state_t                  r_state;
   state_t                  w_state_next;
   logic [ADDR_WIDTH-1:0]   r_cnt;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic [1:0]              r_sel;
   logic [DATA_WIDTH-1:0]   r_wdata;
   logic                    r_wen;
   logic [DATA_WIDTH-1:0]   r_out_data;
   logic                    r_out_valid;
   logic                    r_out_last;
   logic                    r_busy;
   logic                    w_in_ready;
   logic                    w_start;
   logic                    w_accept;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_LOAD_X;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_LOAD_X:     if (w_accept && r_cnt == C_X_LAST) w_state_next = S_LOAD_Y;
         S_LOAD_Y:     if (w_accept && r_cnt == C_Y_LAST) w_state_next = S_DRAIN;
         S_DRAIN:      w_state_next = S_START;
         S_START:      w_state_next = S_ARM;
         S_ARM:        w_state_next = S_WAIT;
         S_WAIT:       if (!mm_busy) w_state_next = S_RD_ISSUE;
         S_RD_ISSUE:   w_state_next = S_RD_CAPTURE;
         S_RD_CAPTURE: w_state_next = S_OUT;
         S_OUT:        if (out_ready) w_state_next = (r_cnt == C_Z_LAST) ? S_LOAD_X : S_RD_ISSUE;
         default:      w_state_next = S_LOAD_X;
      endcase
   end

   always_comb begin
      w_in_ready = (r_state == S_LOAD_X) || (r_state == S_LOAD_Y);
      w_start    = (r_state == S_START);
   end

   assign w_accept = in_valid & w_in_ready;

   // One counter serves all three phases; it is zeroed at every phase boundary.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt       <= '0;
         r_addr      <= '0;
         r_sel       <= 2'd0;
         r_wdata     <= '0;
         r_wen       <= 1'b0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_wen <= w_accept;
         case (r_state)
            S_LOAD_X: if (w_accept) begin
               r_addr  <= r_cnt;
               r_sel   <= 2'd0;
               r_wdata <= in_data;
               r_busy  <= 1'b1;
               r_cnt   <= (r_cnt == C_X_LAST) ? '0 : r_cnt + 1'b1;
            end
            S_LOAD_Y: if (w_accept) begin
               r_addr  <= r_cnt;
               r_sel   <= 2'd1;
               r_wdata <= in_data;
               r_cnt   <= (r_cnt == C_Y_LAST) ? '0 : r_cnt + 1'b1;
            end
            S_WAIT: if (!mm_busy) begin
               r_addr <= r_cnt;
               r_sel  <= 2'd2;
            end
            S_RD_CAPTURE: begin
               r_out_data  <= mm_rdata;
               r_out_valid <= 1'b1;
               r_out_last  <= (r_cnt == C_Z_LAST);
            end
            S_OUT: if (out_ready) begin
               r_out_valid <= 1'b0;
               r_out_last  <= 1'b0;
               if (r_cnt == C_Z_LAST) begin
                  r_cnt  <= '0;
                  r_busy <= 1'b0;
               end else begin
                  r_cnt  <= r_cnt + 1'b1;
                  r_addr <= r_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = w_in_ready;
   assign mm_start  = w_start;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_last  = r_out_last;
   assign seq_busy  = r_busy;
   assign mm_addr   = r_addr;
   assign mm_sel    = r_sel;
   assign mm_wdata  = r_wdata;
   assign mm_wen    = r_wen;

endmodule

// File: tb/tb_matmul_host_sequencer.sv
// Scoreboard bench for matmul_host_sequencer with a behavioural matrix-multiply core model.
module tb_matmul_host_sequencer;
   localparam int AW = 4;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          seq_busy;
   logic [AW-1:0] mm_addr;
   logic          mm_wen;
   logic [1:0]    mm_sel;
   logic [DW-1:0] mm_wdata;
   logic          mm_start;
   logic          mm_busy;
   logic [DW-1:0] mm_rdata = '0;

   always #5 clk = ~clk;

   matmul_host_sequencer #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .X_ROWS(2), .Y_COLS(2), .X_COLS_Y_ROWS(2)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .seq_busy(seq_busy), .mm_addr(mm_addr), .mm_wen(mm_wen), .mm_sel(mm_sel),
      .mm_wdata(mm_wdata), .mm_start(mm_start), .mm_busy(mm_busy), .mm_rdata(mm_rdata)
   );

   // Core model: RAMs, 1-cycle synchronous read, busy for 10 cycles after start.
   logic [DW-1:0] cx [16];
   logic [DW-1:0] cy [16];
   logic [DW-1:0] cz [16];
   int            busy_cnt = 0;
   int            cyc = 0;
   assign mm_busy = (busy_cnt != 0);

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mm_wen && mm_sel == 2'd0) cx[mm_addr] <= mm_wdata;
      if (mm_wen && mm_sel == 2'd1) cy[mm_addr] <= mm_wdata;
      mm_rdata <= cz[mm_addr];
      if (mm_start) begin
         for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
               cz[i*2+j] <= cx[i*2] * cy[j] + cx[i*2+1] * cy[2+j];
         busy_cnt <= 10;
      end else if (busy_cnt > 0) begin
         busy_cnt <= busy_cnt - 1;
      end
   end

   typedef struct {logic [AW-1:0] a; logic [1:0] s; logic [DW-1:0] d;} wr_t;
   typedef struct {logic [DW-1:0] d; logic l;} rs_t;
   wr_t wq[$];
   rs_t rq[$];

   int total = 0;
   int bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   bit            mon_en = 0;
   bit            exp_loading = 1;
   bit            exp_busy = 0;
   bit            acc_prev = 0;
   bit            prev_hold = 0;
   int            acc_cnt = 0;
   int            starts = 0;
   int            last_acc_cyc = -100;
   int            runs_done = 0;
   int            ready_mode = 0;
   int            hold_n = 0;
   logic [DW-1:0] h_data;
   logic          h_last;
   logic [AW-1:0] h_addr;
   wr_t           w_pop;
   rs_t           r_pop;

   // Monitor: samples on the falling edge, checks writes/results against the queues.
   initial begin
      forever begin
         @(negedge clk);
         if (rst || !mon_en) begin
            acc_prev  = 0;
            prev_hold = 0;
         end else begin
            chk("wen_timing", mm_wen, acc_prev);
            if (mm_wen) begin
               if (wq.size() == 0) chk("unexpected_write", 1, 0);
               else begin
                  w_pop = wq.pop_front();
                  chk("wr_addr", mm_addr, w_pop.a);
                  chk("wr_sel", mm_sel, w_pop.s);
                  chk("wr_data", mm_wdata, w_pop.d);
               end
            end
            chk("in_ready", in_ready, exp_loading);
            chk("seq_busy", seq_busy, exp_busy);
            chk("last_without_valid", out_last & ~out_valid, 0);
            if (out_valid) chk("valid_while_core_busy", mm_busy, 0);
            if (mm_start) begin
               chk("start_delay", cyc - last_acc_cyc, 2);
               chk("start_once", starts, 0);
               starts++;
            end
            if (prev_hold) begin
               chk("hold_valid", out_valid, 1);
               chk("hold_data", out_data, h_data);
               chk("hold_last", out_last, h_last);
               chk("hold_addr", mm_addr, h_addr);
            end
            acc_prev = in_valid && in_ready;
            if (acc_prev) begin
               acc_cnt++;
               exp_busy = 1;
               if (acc_cnt == 8) begin
                  exp_loading  = 0;
                  last_acc_cyc = cyc;
               end
            end
            prev_hold = out_valid && !out_ready;
            h_data = out_data;
            h_last = out_last;
            h_addr = mm_addr;
            if (out_valid && out_ready) begin
               if (rq.size() == 0) chk("unexpected_result", 1, 0);
               else begin
                  r_pop = rq.pop_front();
                  $display("result: data=%0d last=%0d (want %0d/%0d)", out_data, out_last, r_pop.d, r_pop.l);
                  chk("out_data", out_data, r_pop.d);
                  chk("out_last", out_last, r_pop.l);
                  if (r_pop.l) begin
                     chk("starts_per_run", starts, 1);
                     starts      = 0;
                     exp_loading = 1;
                     exp_busy    = 0;
                     acc_cnt     = 0;
                     runs_done++;
                  end
               end
            end
         end
      end
   end

   // Downstream ready driver.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            1: if (out_valid && hold_n < 5) begin
                  out_ready = 1'b0;
                  hold_n++;
               end else out_ready = 1'b1;
            2: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b1;
         endcase
      end
   end

   task automatic async_reset();
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_seq_busy", seq_busy, 0);
      chk("rst_mm_wen", mm_wen, 0);
      chk("rst_mm_start", mm_start, 0);
      chk("rst_mm_addr", mm_addr, 0);
      chk("rst_mm_sel", mm_sel, 0);
      chk("rst_mm_wdata", mm_wdata, 0);
      wq.delete();
      rq.delete();
      exp_loading = 1;
      exp_busy    = 0;
      acc_cnt     = 0;
      starts      = 0;
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      chk("in_ready_after_release", in_ready, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [DW-1:0] d, input int gap);
      bit ok;
      int tries;
      in_valid = 1'b0;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      in_valid = 1'b1;
      in_data  = d;
      ok = 0;
      tries = 0;
      while (!ok && tries < 50) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
         tries++;
      end
      if (!ok) chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      in_data  = $urandom;
   endtask

   // gmode: 0 back-to-back, 1 alternate + random gaps, 2 random gaps.
   task automatic run_seq(input logic [DW-1:0] w [8], input int gmode, input int rmode,
                          input bit junk, input bit do_rst);
      logic [DW-1:0] z;
      int target, n, gap;
      for (int i = 0; i < 4; i++) wq.push_back('{a: AW'(i), s: 2'd0, d: w[i]});
      for (int i = 0; i < 4; i++) wq.push_back('{a: AW'(i), s: 2'd1, d: w[4+i]});
      if (!do_rst) begin
         for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
               z = '0;
               for (int k = 0; k < 2; k++) z = z + w[i*2+k] * w[4+k*2+j];
               rq.push_back('{d: z, l: (i == 1 && j == 1)});
            end
      end
      hold_n = 0;
      ready_mode = rmode;
      target = runs_done + 1;
      for (int i = 0; i < 8; i++) begin
         gap = (gmode == 0) ? 0 : (gmode == 1) ? ((i % 2) + $urandom_range(0, 2)) : $urandom_range(0, 3);
         send_word(w[i], gap);
      end
      if (do_rst) begin
         n = 0;
         while (!mm_busy && n < 50) begin
            @(posedge clk);
            #1;
            n++;
         end
         chk("core_busy_seen", mm_busy, 1);
         repeat (3) @(posedge clk);
         async_reset();
      end else begin
         n = 0;
         while (runs_done < target && n < 500) begin
            @(posedge clk);
            #1;
            if (junk) begin
               in_valid = mm_busy;
               in_data  = $urandom;
            end
            n++;
         end
         in_valid = 1'b0;
         chk("run_complete", runs_done, target);
      end
      $display("run finished: gmode=%0d rmode=%0d reset=%0d", gmode, rmode, do_rst);
   endtask

   logic [DW-1:0] words [8];

   initial begin
      repeat (2) @(posedge clk);
      async_reset();
      mon_en = 1;

      words = '{1, 2, 3, 4, 5, 6, 7, 8};
      run_seq(words, 0, 1, 0, 0);
      run_seq(words, 1, 0, 1, 0);
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 8; i++) words[i] = $urandom;
         run_seq(words, 2, 2, 1, 0);
      end
      for (int i = 0; i < 8; i++) words[i] = $urandom_range(0, 1000);
      run_seq(words, 2, 0, 0, 1);
      words = '{1, 0, 0, 1, 5, 6, 7, 8};
      run_seq(words, 0, 0, 0, 0);

      repeat (3) @(posedge clk);
      chk("final_in_ready", in_ready, 1);
      chk("final_seq_busy", seq_busy, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
